// File: rtl/iz_param_loader.sv
// -----------------------------------------------------------------------------
// iz_param_loader
//
// Byte-serial loader for the Izhikevich neuron core parameters. It receives a
// 10-byte frame on an 8-bit bus:
//     SYNC, a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi, chk
// where chk is the XOR of the eight data bytes. The data bytes are assembled in
// shadow registers. All four parameters are then committed together on the edge
// that samples a matching checksum.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   data_in      in   8   loader byte
//   data_valid   in   1   data_in is sampled on every rising edge where this is 1
//   param_a..d   out  16  committed parameters, two's complement
//   params_ready out  1   committed set is trustworthy (low while a frame loads)
//   busy         out  1   a frame is in progress (DATA or CHECK)
//   load_error   out  1   sticky: the last frame failed (checksum or timeout)
// -----------------------------------------------------------------------------
module iz_param_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,  // 0 disables the timeout
    parameter logic [15:0] DEFAULT_A      = 16'h0001,
    parameter logic [15:0] DEFAULT_B      = 16'h000D,
    parameter logic [15:0] DEFAULT_C      = 16'hEFC0,
    parameter logic [15:0] DEFAULT_D      = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        busy,
    output logic        load_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic [7:0]  xor_acc;
    logic [15:0] idle_cnt;
    logic        have_valid;
    logic [7:0]  shadow [8];

    logic        sync_hit;
    logic        data_take;
    logic        chk_take;
    logic        chk_ok;
    logic        commit;
    logic        timeout;
    logic [15:0] idle_next;

    // Saturating increment: a stalled frame with the timeout disabled must
    // not wrap back to a small count.
    assign idle_next = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;

    assign sync_hit  = (state == IDLE)  && data_valid && (data_in == SYNC_BYTE);
    assign data_take = (state == DATA)  && data_valid;
    assign chk_take  = (state == CHECK) && data_valid;
    assign chk_ok    = (data_in == xor_acc);
    assign commit    = chk_take && chk_ok;

    // The abort happens on the idle edge that would bring the count to
    // TIMEOUT_CYCLES. A byte on that edge is accepted instead.
    assign timeout   = (state != IDLE) && !data_valid &&
                       (TIMEOUT_CYCLES != 16'd0) && (idle_next == TIMEOUT_CYCLES);

    assign busy      = (state != IDLE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is assigned with <= so every register
            // samples pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // state_next, so no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (sync_hit) state_next = DATA;
            DATA:    if (timeout) state_next = IDLE;
                     else if (data_take && idx == 3'd7) state_next = CHECK;
            CHECK:   if (timeout || chk_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ shadow bytes
    // NOTE: the shadow bytes have no reset. They are read only on a commit,
    // and a commit always follows the writing of all eight bytes of the frame.
    always_ff @(posedge clk) begin
        if (data_take) begin
            shadow[idx] <= data_in;
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= 3'd0;
            xor_acc      <= 8'd0;
            idle_cnt     <= 16'd0;
            have_valid   <= 1'b0;
            params_ready <= 1'b0;
            load_error   <= 1'b0;
            param_a      <= DEFAULT_A;
            param_b      <= DEFAULT_B;
            param_c      <= DEFAULT_C;
            param_d      <= DEFAULT_D;
        end else begin
            if (sync_hit) begin
                idx     <= 3'd0;
                xor_acc <= 8'd0;
            end else if (data_take) begin
                idx     <= idx + 3'd1;
                xor_acc <= xor_acc ^ data_in;
            end

            if (state == IDLE || data_valid) begin
                idle_cnt <= 16'd0;
            end else begin
                idle_cnt <= idle_next;
            end

            if (sync_hit) begin
                params_ready <= 1'b0;
            end else if (commit) begin
                param_a      <= {shadow[1], shadow[0]};
                param_b      <= {shadow[3], shadow[2]};
                param_c      <= {shadow[5], shadow[4]};
                param_d      <= {shadow[7], shadow[6]};
                have_valid   <= 1'b1;
                params_ready <= 1'b1;
                load_error   <= 1'b0;
            end else if (chk_take || timeout) begin
                // The previously committed set is untouched, so it is
                // trusted again if one was ever committed.
                params_ready <= have_valid;
                load_error   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iz_param_loader.sv
// -----------------------------------------------------------------------------
// tb_iz_param_loader
//
// Self-checking bench for iz_param_loader, which is built with
// TIMEOUT_CYCLES = 4. The reference model works on frames. It collects the
// bytes of the current frame in a queue, counts idle cycles between them, and
// judges a frame once all nine post-sync bytes are present. Directed scenarios
// come first, followed by randomized frames with noise, gaps and bad checksums.
// -----------------------------------------------------------------------------
module tb_iz_param_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 4;

    localparam logic [15:0] DEF_A = 16'h0001;
    localparam logic [15:0] DEF_B = 16'h000D;
    localparam logic [15:0] DEF_C = 16'hEFC0;
    localparam logic [15:0] DEF_D = 16'h0200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        params_ready, busy, load_error;

    iz_param_loader #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (16'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .busy         (busy),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------ reference model
    logic [15:0] m_a, m_b, m_c, m_d;
    bit          m_ready, m_err, m_have, m_in_frame;
    int          m_gap;
    logic [7:0]  m_frame[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = DEF_A; m_b = DEF_B; m_c = DEF_C; m_d = DEF_D;
        m_ready = 0; m_err = 0; m_have = 0; m_in_frame = 0; m_gap = 0;
        m_frame.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        logic [7:0] x;
        if (!m_in_frame) begin
            if (v && b == SYNC) begin
                m_in_frame = 1; m_ready = 0; m_gap = 0;
                m_frame.delete();
            end
        end else if (v) begin
            m_gap = 0;
            m_frame.push_back(b);
            if (m_frame.size() == 9) begin
                x = 8'h00;
                for (int i = 0; i < 8; i++) x ^= m_frame[i];
                if (m_frame[8] == x) begin
                    m_a = {m_frame[1], m_frame[0]};
                    m_b = {m_frame[3], m_frame[2]};
                    m_c = {m_frame[5], m_frame[4]};
                    m_d = {m_frame[7], m_frame[6]};
                    m_have = 1; m_ready = 1; m_err = 0;
                end else begin
                    m_err = 1; m_ready = m_have;
                end
                m_in_frame = 0;
            end
        end else begin
            m_gap++;
            if (m_gap == TMO) begin
                m_in_frame = 0; m_err = 1; m_ready = m_have;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".a"},     param_a, m_a);
        check({tag, ".b"},     param_b, m_b);
        check({tag, ".c"},     param_c, m_c);
        check({tag, ".d"},     param_d, m_d);
        check({tag, ".ready"}, {15'd0, params_ready}, {15'd0, m_ready});
        check({tag, ".busy"},  {15'd0, busy},         {15'd0, m_in_frame});
        check({tag, ".err"},   {15'd0, load_error},   {15'd0, m_err});
    endtask

    // Drive one cycle and update the model on the edge. Outputs are compared
    // 1 time unit after the edge, which is also where the next inputs are driven.
    task automatic step(input bit v, input logic [7:0] b, input string tag);
        data_valid = v;
        data_in    = b;
        @(posedge clk);
        model_step(v, b);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, $urandom, tag);
    endtask

    // Frame data is packed {d_hi,d_lo,c_hi,c_lo,b_hi,b_lo,a_hi,a_lo}.
    // A gap of up to max_gap idle cycles is placed before each post-sync byte.
    task automatic send_frame(input logic [63:0] data, input bit bad,
                              input int max_gap, input string tag);
        logic [7:0] x;
        logic [7:0] bv;
        x = 8'h00;
        step(1, SYNC, tag);
        for (int i = 0; i < 8; i++) begin
            bv = data[8*i +: 8];
            x ^= bv;
            if (max_gap > 0) idle($urandom_range(max_gap, 0), tag);
            step(1, bv, tag);
        end
        if (max_gap > 0) idle($urandom_range(max_gap, 0), tag);
        step(1, bad ? (x ^ 8'h01) : x, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    localparam logic [63:0] GOOD = 64'h0080_F380_000D_0002;

    initial begin
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Timeout with no prior commit: abort on the 4th idle edge.
        step(1, SYNC, "to"); step(1, 8'h01, "to"); step(1, 8'h02, "to");
        idle(3, "to");
        check("to_busy_before", {15'd0, busy}, 16'd1);
        idle(1, "to");
        check("to_busy",  {15'd0, busy},         16'd0);
        check("to_err",   {15'd0, load_error},   16'd1);
        check("to_ready", {15'd0, params_ready}, 16'd0);
        check("to_a",     param_a,               DEF_A);

        // A byte on the 4th idle edge wins over the timeout.
        step(1, SYNC, "to2"); step(1, 8'h01, "to2"); step(1, 8'h02, "to2");
        idle(3, "to2");
        step(1, 8'h03, "to2");
        check("to2_busy", {15'd0, busy}, 16'd1);
        idle(4, "to2");
        check("to2_abort", {15'd0, busy}, 16'd0);

        // Good frame, back to back.
        send_frame(GOOD, 0, 0, "good");
        check("good_a", param_a, 16'h0002);
        check("good_b", param_b, 16'h000D);
        check("good_c", param_c, 16'hF380);
        check("good_d", param_d, 16'h0080);
        check("good_ready", {15'd0, params_ready}, 16'd1);
        check("good_err",   {15'd0, load_error},   16'd0);

        // Bad checksum (FD) keeps the committed set.
        send_frame(GOOD, 1, 0, "bad");
        check("bad_a",     param_a, 16'h0002);
        check("bad_ready", {15'd0, params_ready}, 16'd1);
        check("bad_err",   {15'd0, load_error},   16'd1);
        send_frame(GOOD, 0, 0, "clr");
        check("clr_err", {15'd0, load_error}, 16'd0);

        // Leading noise is ignored, and a sync value inside the data is plain data.
        step(1, 8'h00, "noise"); step(1, 8'h33, "noise");
        send_frame(64'h0080_F380_000D_00A5, 0, 0, "embed");
        check("embed_a", param_a, 16'h00A5);

        // Reset in the middle of a frame, then a clean frame.
        step(1, SYNC, "mid");
        for (int i = 0; i < 5; i++) step(1, $urandom, "mid");
        async_reset("mid_reset");
        @(posedge clk);
        #1;
        send_frame(GOOD, 0, 0, "after_rst");
        check("after_rst_c", param_c, 16'hF380);
        check("after_rst_ready", {15'd0, params_ready}, 16'd1);

        // Randomized frames with noise, gaps, timeouts and corrupted checksums.
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(3, 0) == 0) step(1, $urandom, "rnd_noise");
            if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1), "rnd_idle");
            send_frame({$urandom, $urandom}, ($urandom_range(4, 0) == 0),
                       ($urandom_range(5, 0) == 0) ? 5 : 1, "rnd");
            idle($urandom_range(4, 0), "rnd_tail");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
